// File: rtl/pc_ir_unit_pkg.sv
// Shared constants for the PC / instruction-register unit.
// Holds the branch funct3 encodings, the reset PC default and the NOP encoding.
package pc_ir_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

endpackage

// File: rtl/pc_ir_unit_branch_cond_eval.sv
// Combinational branch condition evaluation from funct3 and the flags of rs1-rs2.
// Carry is the no-borrow flag, so unsigned rs1 < rs2 is !Carry.
module branch_cond_eval
  import pc_ir_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       neg,
  input  logic       ovf,
  input  logic       carry,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = !zero;
      F3_BLT:  cond = neg ^ ovf;
      F3_BGE:  cond = !(neg ^ ovf);
      F3_BLTU: cond = !carry;
      F3_BGEU: cond = carry;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter and instruction register with branch resolution,
// sticky misaligned-target fault capture and mcycle/minstret counters.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCUpdate,
  input  logic        Branch,
  input  logic        IRWrite,
  input  logic [31:0] PCNext,
  input  logic [31:0] ReadData,
  input  logic        Zero,
  input  logic        Neg,
  input  logic        Ovf,
  input  logic        Carry,
  output logic [31:0] PC,
  output logic [31:0] OldPC,
  output logic [31:0] Instr,
  output logic        PCWrite,
  output logic        BranchTaken,
  output logic        MisalignFault,
  output logic [31:0] FaultAddr,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  logic cond;
  logic misaligned;
  logic fetched;

  // Decode from the registered instruction; ReadData may already hold the next fetch.
  branch_cond_eval u_cond (
    .funct3 (Instr[14:12]),
    .zero   (Zero),
    .neg    (Neg),
    .ovf    (Ovf),
    .carry  (Carry),
    .cond   (cond)
  );

  assign BranchTaken = Branch & cond;
  assign PCWrite     = PCUpdate | BranchTaken;
  assign misaligned  = |PCNext[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      PC            <= RESET_PC;
      OldPC         <= 32'h0000_0000;
      Instr         <= NOP_INSTR;
      MisalignFault <= 1'b0;
      FaultAddr     <= 32'h0000_0000;
      mcycle        <= 64'd0;
      minstret      <= 64'd0;
      fetched       <= 1'b0;
    end else begin
      mcycle <= mcycle + 64'd1;

      // A misaligned target is rejected; only the first one is remembered.
      if (PCWrite) begin
        if (!misaligned) begin
          PC <= PCNext;
        end else if (!MisalignFault) begin
          MisalignFault <= 1'b1;
          FaultAddr     <= PCNext;
        end
      end

      // OldPC samples the pre-update PC even when PC is written on the same edge.
      if (IRWrite) begin
        Instr   <= ReadData;
        OldPC   <= PC;
        fetched <= 1'b1;
        if (fetched) minstret <= minstret + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed self-checking bench for pc_ir_unit.
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCUpdate, Branch, IRWrite;
  logic [31:0] PCNext, ReadData;
  logic        Zero, Neg, Ovf, Carry;
  logic [31:0] PC, OldPC, Instr, FaultAddr;
  logic        PCWrite, BranchTaken, MisalignFault;
  logic [63:0] mcycle, minstret;

  int errors = 0;
  int checks = 0;

  pc_ir_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCUpdate      (PCUpdate),
    .Branch        (Branch),
    .IRWrite       (IRWrite),
    .PCNext        (PCNext),
    .ReadData      (ReadData),
    .Zero          (Zero),
    .Neg           (Neg),
    .Ovf           (Ovf),
    .Carry         (Carry),
    .PC            (PC),
    .OldPC         (OldPC),
    .Instr         (Instr),
    .PCWrite       (PCWrite),
    .BranchTaken   (BranchTaken),
    .MisalignFault (MisalignFault),
    .FaultAddr     (FaultAddr),
    .mcycle        (mcycle),
    .minstret      (minstret)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic idle_inputs();
    PCUpdate = 1'b0; Branch = 1'b0; IRWrite = 1'b0;
    PCNext = 32'h0; ReadData = 32'h0;
    Zero = 1'b0; Neg = 1'b0; Ovf = 1'b0; Carry = 1'b0;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Load an instruction word without touching PC.
  task automatic load_instr(input logic [31:0] word);
    idle_inputs();
    IRWrite  = 1'b1;
    ReadData = word;
    step();
    IRWrite  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; PCUpdate = 1'b1; IRWrite = 1'b1;
    PCNext = 32'h40; ReadData = 32'hdead_beef;
    #1;
    check32("reset_pcwrite_comb", {31'b0, PCWrite}, 32'h1);
    step();
    check32("reset_pc", PC, 32'h0);
    check32("reset_oldpc", OldPC, 32'h0);
    check32("reset_instr", Instr, 32'h0000_0013);
    check32("reset_fault", {31'b0, MisalignFault}, 32'h0);
    check32("reset_faultaddr", FaultAddr, 32'h0);
    check64("reset_mcycle", mcycle, 64'd0);
    check64("reset_minstret", minstret, 64'd0);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_fetch();
    do_reset();
    IRWrite = 1'b1; PCUpdate = 1'b1; PCNext = 32'h4; ReadData = 32'h0050_0093;
    #1;
    check32("fetch_pcwrite", {31'b0, PCWrite}, 32'h1);
    step();
    check32("fetch_pc", PC, 32'h4);
    check32("fetch_oldpc", OldPC, 32'h0);
    check32("fetch_instr", Instr, 32'h0050_0093);
    check64("fetch_minstret", minstret, 64'd0);
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    load_instr(32'h0020_8063);  // beq
    Branch = 1'b1; Zero = 1'b1; PCNext = 32'h20;
    #1;
    check32("beq_taken_pcwrite", {31'b0, PCWrite}, 32'h1);
    check32("beq_taken_bt", {31'b0, BranchTaken}, 32'h1);
    step();
    check32("beq_taken_pc", PC, 32'h20);
    // ReadData carries a bne word; decode must still use the registered beq.
    Zero = 1'b0; PCNext = 32'h40; ReadData = 32'h0020_9063;
    #1;
    check32("beq_not_taken_pcwrite", {31'b0, PCWrite}, 32'h0);
    step();
    check32("beq_not_taken_pc", PC, 32'h20);
    Branch = 1'b0; Zero = 1'b1;
    #1;
    check32("branch_gated_bt", {31'b0, BranchTaken}, 32'h0);
    idle_inputs();
  endtask

  task automatic test_conditions();
    // Flags Z=0, N=1, V=0, C=1: expected per funct3 000..111.
    logic exp_cond [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int f = 0; f < 8; f++) begin
      load_instr(32'h0000_0063 | (32'(f) << 12));
      Branch = 1'b1; Zero = 1'b0; Neg = 1'b1; Ovf = 1'b0; Carry = 1'b1;
      #1;
      check32($sformatf("cond_f3_%0d", f), {31'b0, BranchTaken}, {31'b0, exp_cond[f]});
      idle_inputs();
    end
  endtask

  task automatic test_misalign();
    do_reset();
    PCUpdate = 1'b1; PCNext = 32'h6;
    step();
    check32("mis1_pc", PC, 32'h0);
    check32("mis1_flag", {31'b0, MisalignFault}, 32'h1);
    check32("mis1_addr", FaultAddr, 32'h6);
    PCNext = 32'hA;
    step();
    check32("mis2_pc", PC, 32'h0);
    check32("mis2_addr", FaultAddr, 32'h6);
    PCNext = 32'h8;
    step();
    check32("mis_aligned_pc", PC, 32'h8);
    check32("mis_sticky", {31'b0, MisalignFault}, 32'h1);
    // Simultaneous fetch and PC write: OldPC gets the pre-update PC.
    IRWrite = 1'b1; ReadData = 32'h0000_1111; PCNext = 32'h10;
    step();
    check32("simul_pc", PC, 32'h10);
    check32("simul_oldpc", OldPC, 32'h8);
    check32("simul_instr", Instr, 32'h0000_1111);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    IRWrite = 1'b1; PCUpdate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCNext = 32'(4 * (i + 1));
      ReadData = 32'h100 + 32'(i);
      step();
    end
    check64("b2b_minstret", minstret, 64'd2);
    check64("b2b_mcycle", mcycle, 64'd3);
    check32("b2b_pc", PC, 32'hC);
    check32("b2b_oldpc", OldPC, 32'h8);
    idle_inputs();
    PCNext = 32'h80; ReadData = 32'hFFFF_FFFF;
    step();
    step();
    check64("idle_mcycle", mcycle, 64'd5);
    check64("idle_minstret", minstret, 64'd2);
    check32("idle_pc", PC, 32'hC);
    check32("idle_oldpc", OldPC, 32'h8);
    check32("idle_instr", Instr, 32'h102);
  endtask

  task automatic test_reset_midstream();
    PCUpdate = 1'b1; IRWrite = 1'b1; PCNext = 32'h200; ReadData = 32'h1234_5678;
    reset = 1'b1;
    step();
    check32("rst_mid_pc", PC, 32'h0);
    check32("rst_mid_instr", Instr, 32'h0000_0013);
    check64("rst_mid_mcycle", mcycle, 64'd0);
    check64("rst_mid_minstret", minstret, 64'd0);
    reset = 1'b0;
    idle_inputs();
    // First fetch after reset must not retire anything.
    load_instr(32'h0000_2222);
    check64("rst_mid_first_fetch", minstret, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_fetch();
    test_branch();
    test_conditions();
    test_misalign();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
